ntt_switch_sched: RTL and testbench

- Sequences one column of 2x2 registered switch cells inside the stride-permutation network of the streaming NTT (N=1024, P=32 lanes, so 16 switches per column).
- Counts data beats within each frame and generates the per-switch control vector, time-aligned to when each beat reaches the switch inputs.
- Provides a start/busy/done frame handshake and an aligned output-valid for the downstream stage.

---
 rtl/ntt_switch_sched.sv | 102 ++++++++++
 tb/tb_ntt_switch_sched.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ntt_switch_sched.sv
// ntt_switch_sched: beat counter and switch-control sequencer for one 2x2 switch column of the NTT stride permutation (optional stall counter: NTT_SWSCHED_STALL_CNT_EN)
module ntt_switch_sched #(
  parameter int NUM_SW     = 16,
  parameter int FRAME_LEN  = 32,
  parameter int SWAP_SHIFT = 2,
  parameter int IN_LAT     = 1,
  parameter int FRM_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [FRM_W-1:0]  num_frames,
  input  logic [NUM_SW-1:0] lane_mask,
  input  logic              in_valid,
  output logic [NUM_SW-1:0] sw_ctrl,
  output logic              out_valid,
  output logic              busy,
  output logic              done,
  output logic              err_unexp,
  output logic [15:0]       stall_cnt
);
  localparam int CW = $clog2(FRAME_LEN);
  localparam int DW = $clog2(IN_LAT + 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  logic [1:0]        state, nxt;
  logic [CW-1:0]     beat_cnt;
  logic [FRM_W-1:0]  frames_left;
  logic [NUM_SW-1:0] mask_q, ctrl_q;
  logic [DW-1:0]     drain_cnt;
  logic [IN_LAT-1:0] v_pipe, s_pipe;
  logic              start_ok, acc, wrap, last_drain, tap_v;
  assign start_ok   = start && state == IDLE;
  assign acc        = in_valid && state == RUN;
  assign wrap       = acc && beat_cnt == CW'(FRAME_LEN - 1);
  assign last_drain = state == DRAIN && drain_cnt == DW'(IN_LAT);
  assign tap_v      = v_pipe[IN_LAT-1];
  // Control is driven straight from the pipeline tap so it is valid while the beat sits at the switch inputs; otherwise it holds.
  assign sw_ctrl    = tap_v ? ({NUM_SW{s_pipe[IN_LAT-1]}} & mask_q) : ctrl_q;
  assign done       = last_drain;
  // Next-state: a start is only honoured in IDLE, so a start coinciding with done is dropped.
  always_comb
    nxt = start_ok ? RUN : (wrap && frames_left == FRM_W'(1)) ? DRAIN : last_drain ? IDLE : state;
  // Frame sequencing: beat counter, frame countdown, drain timer and job parameters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      beat_cnt    <= '0;
      frames_left <= '0;
      mask_q      <= '0;
      drain_cnt   <= '0;
      err_unexp   <= 1'b0;
    end else begin
      state     <= nxt;
      busy      <= nxt != IDLE;
      drain_cnt <= (state == DRAIN && !last_drain) ? drain_cnt + 1'b1 : '0;
      err_unexp <= err_unexp | (in_valid && state != RUN);
      if (start_ok) begin
        mask_q      <= lane_mask;
        frames_left <= (num_frames == '0) ? FRM_W'(1) : num_frames;
        beat_cnt    <= '0;
      end else if (acc) begin
        beat_cnt <= beat_cnt + 1'b1;
        if (wrap && frames_left != FRM_W'(1))
          frames_left <= frames_left - 1'b1;
      end
    end
  end
  // Delay line carrying {valid, swap} to the switch inputs, plus held control and the switch-register valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_pipe    <= '0;
      s_pipe    <= '0;
      ctrl_q    <= '0;
      out_valid <= 1'b0;
    end else begin
      v_pipe[0] <= acc;
      s_pipe[0] <= beat_cnt[SWAP_SHIFT];
      for (int i = 1; i < IN_LAT; i++) begin
        v_pipe[i] <= v_pipe[i-1];
        s_pipe[i] <= s_pipe[i-1];
      end
      ctrl_q    <= sw_ctrl;
      out_valid <= tap_v;
    end
  end
`ifdef NTT_SWSCHED_STALL_CNT_EN
  // Saturating count of RUN cycles without a beat; cleared by an accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt <= '0;
    else if (start_ok)
      stall_cnt <= '0;
    else if (state == RUN && !in_valid && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 1'b1;
  end
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_ntt_switch_sched.sv
// tb_ntt_switch_sched: directed self-checking bench for ntt_switch_sched
module tb_ntt_switch_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, start2 = 1'b0;
  logic [7:0]  num_frames = 8'd1;
  logic [15:0] lane_mask = 16'h0;
  logic        in_valid = 1'b0, in_valid2 = 1'b0;
  logic [15:0] sw_ctrl, sw_ctrl2, stall_cnt, stall_cnt2;
  logic        out_valid, busy, done, err_unexp;
  logic        out_valid2, busy2, done2, err_unexp2;
  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_ctrl = 16'h0;
  logic        exp_err = 1'b0;

  ntt_switch_sched dut (
    .clk(clk), .rst(rst), .start(start), .num_frames(num_frames), .lane_mask(lane_mask),
    .in_valid(in_valid), .sw_ctrl(sw_ctrl), .out_valid(out_valid), .busy(busy), .done(done),
    .err_unexp(err_unexp), .stall_cnt(stall_cnt)
  );

  ntt_switch_sched #(.IN_LAT(3), .SWAP_SHIFT(0)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .num_frames(num_frames), .lane_mask(lane_mask),
    .in_valid(in_valid2), .sw_ctrl(sw_ctrl2), .out_valid(out_valid2), .busy(busy2), .done(done2),
    .err_unexp(err_unexp2), .stall_cnt(stall_cnt2)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1;
    total++; if ({sw_ctrl, out_valid, busy, done, err_unexp, stall_cnt} !== 36'h0) begin bad++; $display("FAIL reset_state got=%h exp=0", {sw_ctrl, out_valid, busy, done, err_unexp, stall_cnt}); end
    total++; if ({sw_ctrl2, out_valid2, busy2, done2, err_unexp2} !== 20'h0) begin bad++; $display("FAIL reset_state2 got=%h exp=0", {sw_ctrl2, out_valid2, busy2, done2, err_unexp2}); end
    tick();
    rst = 1'b1;
    tick();
  endtask

  // One job on the default instance; beat j arrives at cycle 1+j*(gap+1), its control shows 1 cycle later.
  task automatic check_job(input logic [15:0] mask, input logic [7:0] nf, input int gap, input bit bogus);
    int nb, last, d, exp_stall;
    bit tapped, prev_tap;
    nb = (nf == 0 ? 1 : int'(nf)) * 32;
    last = 1 + (nb - 1) * (gap + 1);
    prev_tap = 0;
    for (int k = 0; k <= last + 4; k++) begin
      start = (k == 0) || (bogus && (k == 5 || k == last + 2));
      lane_mask = (k == 0) ? mask : ~mask;
      num_frames = (k == 0) ? nf : 8'h55;
      in_valid = (k >= 1 && k <= last && (k - 1) % (gap + 1) == 0) || (bogus && k == last + 1);
      d = k - 2;
      tapped = d >= 0 && d % (gap + 1) == 0 && d / (gap + 1) < nb;
      if (tapped) exp_ctrl = (((d / (gap + 1)) >> 2) & 1) != 0 ? mask : 16'h0;
      if (bogus && k == last + 2) exp_err = 1'b1;
      total++; if (sw_ctrl !== exp_ctrl) begin bad++; $display("FAIL sw_ctrl k=%0d got=%h exp=%h", k, sw_ctrl, exp_ctrl); end
      total++; if (out_valid !== prev_tap) begin bad++; $display("FAIL out_valid k=%0d got=%b exp=%b", k, out_valid, prev_tap); end
      total++; if (busy !== (k >= 1 && k <= last + 2)) begin bad++; $display("FAIL busy k=%0d got=%b", k, busy); end
      total++; if (done !== (k == last + 2)) begin bad++; $display("FAIL done k=%0d got=%b", k, done); end
      total++; if (err_unexp !== exp_err) begin bad++; $display("FAIL err_unexp k=%0d got=%b exp=%b", k, err_unexp, exp_err); end
      prev_tap = tapped;
      tick();
    end
    start = 1'b0;
    in_valid = 1'b0;
`ifdef NTT_SWSCHED_STALL_CNT_EN
    exp_stall = (nb - 1) * gap;
`else
    exp_stall = 0;
`endif
    total++; if (stall_cnt !== 16'(exp_stall)) begin bad++; $display("FAIL stall_cnt got=%0d exp=%0d", stall_cnt, exp_stall); end
  endtask

  task automatic test_basic;
    check_job(16'hFFFF, 8'd1, 0, 0);
  endtask

  task automatic test_mask_stalls;
    check_job(16'h00F0, 8'd1, 1, 0);
  endtask

  task automatic test_multi_frame;
    check_job(16'hA5A5, 8'd3, 0, 0);
    check_job(16'h0F0F, 8'd0, 0, 0);
  endtask

  task automatic test_protocol;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    exp_err = 1'b1;
    for (int k = 0; k < 3; k++) begin
      total++; if (err_unexp !== 1'b1) begin bad++; $display("FAIL idle_err k=%0d got=%b exp=1", k, err_unexp); end
      total++; if (sw_ctrl !== exp_ctrl) begin bad++; $display("FAIL idle_ctrl k=%0d got=%h exp=%h", k, sw_ctrl, exp_ctrl); end
      total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL idle_ov k=%0d got=%b%b exp=00", k, out_valid, busy); end
      tick();
    end
    check_job(16'h3C3C, 8'd1, 0, 1);
  endtask

  task automatic test_async_reset;
    start = 1'b1;
    lane_mask = 16'hFFFF;
    num_frames = 8'd1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 11; k++) begin
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    total++; if ({sw_ctrl, out_valid, busy, done, err_unexp, stall_cnt} !== 36'h0) begin bad++; $display("FAIL async_reset got=%h exp=0", {sw_ctrl, out_valid, busy, done, err_unexp, stall_cnt}); end
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if ({out_valid, busy, done} !== 3'b000) begin bad++; $display("FAIL reset_hold k=%0d got=%b exp=000", k, {out_valid, busy, done}); end
    end
    #3 rst = 1'b1;
    exp_ctrl = 16'h0;
    exp_err = 1'b0;
    tick();
    check_job(16'hFFFF, 8'd1, 0, 0);
  endtask

  task automatic test_sweep;
    logic [15:0] e2;
    bit tp, ptp;
    e2 = 16'h0;
    ptp = 0;
    for (int k = 0; k <= 40; k++) begin
      start2 = (k == 0);
      lane_mask = 16'hFFFF;
      num_frames = 8'd1;
      in_valid2 = (k >= 1 && k <= 32);
      tp = (k >= 4 && k <= 35);
      if (tp) e2 = ((k - 4) & 1) != 0 ? 16'hFFFF : 16'h0;
      total++; if (sw_ctrl2 !== e2) begin bad++; $display("FAIL sweep_ctrl k=%0d got=%h exp=%h", k, sw_ctrl2, e2); end
      total++; if (out_valid2 !== ptp) begin bad++; $display("FAIL sweep_ov k=%0d got=%b exp=%b", k, out_valid2, ptp); end
      total++; if (busy2 !== (k >= 1 && k <= 36)) begin bad++; $display("FAIL sweep_busy k=%0d got=%b", k, busy2); end
      total++; if (done2 !== (k == 36)) begin bad++; $display("FAIL sweep_done k=%0d got=%b", k, done2); end
      ptp = tp;
      tick();
    end
    start2 = 1'b0;
    in_valid2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mask_stalls();
    test_multi_frame();
    test_protocol();
    test_async_reset();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
